// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared types and constants for the 10-bit LFSR random source
package lfsr_pkg;

  typedef logic [9:0] rand_t;

  localparam rand_t LFSR_TAPS_10   = 10'b1001000000;
  localparam rand_t LFSR_SEED_10   = 10'h000;
  localparam int    LFSR_PERIOD_10 = 1023;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } hs_state_t;

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - XNOR LFSR state register with seed load and lockup replacement
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int                 WIDTH = 10,
  parameter logic [WIDTH-1:0]   TAPS  = LFSR_TAPS_10,
  parameter logic [WIDTH-1:0]   SEED  = LFSR_SEED_10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] lfsr_q,
  output logic             lockup_err
);

  // All-ones is the one state an XNOR LFSR can never leave, so it is never accepted as a seed.
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] r_lfsr;
  logic             r_lockup;
  logic             w_fb;
  logic [WIDTH-1:0] w_next;
  logic             w_seed_illegal;

  assign w_fb           = ~^(r_lfsr & TAPS);
  assign w_next         = {r_lfsr[WIDTH-2:0], w_fb};
  assign w_seed_illegal = (seed_in == ALL_ONES);

  // State update: load beats en, en beats hold; illegal seeds fall back to SEED.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr   <= SEED;
      r_lockup <= 1'b0;
    end else begin
      r_lockup <= load && w_seed_illegal;
      if (load) begin
        r_lfsr <= w_seed_illegal ? SEED : seed_in;
      end else if (en) begin
        r_lfsr <= w_next;
      end
    end
  end

  assign lfsr_q     = r_lfsr;
  assign lockup_err = r_lockup;

endmodule

// File: rtl/lfsr10_source.sv
// rtl/lfsr10_source.sv - LFSR random source with step counter and req/ack sample handshake
module lfsr10_source
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 10,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_10,
  parameter logic [WIDTH-1:0] SEED  = LFSR_SEED_10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  output logic             ack,
  output logic [WIDTH-1:0] rand_out,
  output logic [WIDTH-1:0] lfsr_q,
  output logic [WIDTH-1:0] steps,
  output logic             period_wrap,
  output logic             lockup_err
);

  // The counter runs over the LFSR period, 2^WIDTH-1 states, so its last value is 2^WIDTH-2.
  localparam int               PERIOD    = (WIDTH == 10) ? LFSR_PERIOD_10 : ((1 << WIDTH) - 1);
  localparam logic [WIDTH-1:0] STEP_LAST = WIDTH'(PERIOD - 1);

  logic [WIDTH-1:0] w_lfsr;
  logic [WIDTH-1:0] r_steps;
  logic             r_wrap;
  logic [WIDTH-1:0] r_rand;
  logic             r_ack;
  hs_state_t        r_state;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load       (load),
    .seed_in    (seed_in),
    .lfsr_q     (w_lfsr),
    .lockup_err (lockup_err)
  );

  // Step counter follows the core's priority: a load restarts it, an en step advances it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_steps <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (load) begin
        r_steps <= '0;
      end else if (en) begin
        if (r_steps == STEP_LAST) begin
          r_steps <= '0;
          r_wrap  <= 1'b1;
        end else begin
          r_steps <= r_steps + 1'b1;
        end
      end
    end
  end

  // Four-phase handshake: capture the pre-step state once per req, then wait for req to drop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_rand  <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req) begin
            r_rand  <= w_lfsr;
            r_ack   <= 1'b1;
            r_state <= ACK;
          end
        end
        ACK: begin
          r_state <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (!req) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ack         = r_ack;
  assign rand_out    = r_rand;
  assign lfsr_q      = w_lfsr;
  assign steps       = r_steps;
  assign period_wrap = r_wrap;

endmodule
